// File: rtl/writeback_register_file_if.sv
// Writeback/issue/read bundle for writeback_register_file.
// wb_bus layout: {out_port[DATA_W-1:0], wb_value[DATA_W-1:0], wb_rd[ADDR_W-1:0], wb_en}.
interface writeback_register_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [2*DATA_W+ADDR_W:0] wb_bus;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_rd;
    logic [ADDR_W-1:0]        rs1_addr;
    logic [ADDR_W-1:0]        rs2_addr;
    logic [DATA_W-1:0]        rs1_data;
    logic [DATA_W-1:0]        rs2_data;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic                     stall;
    logic                     iss_full;
    logic                     err;

    modport master (
        output wb_bus, iss_en, iss_rd, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, iss_full, err
    );

    modport slave (
        input  wb_bus, iss_en, iss_rd, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, iss_full, err
    );
endinterface

// File: rtl/writeback_register_file.sv
// Register file with per-register pending-write scoreboard and two combinational read ports.
// Optional write-through bypass from the writeback bus: define RF_BYPASS_EN.
module writeback_register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    writeback_register_file_if.slave   rf
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                        err_q, err_d;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_value;
    logic              unused_out_port;
    logic              iss_full;
    logic              rs1_busy, rs2_busy;

    assign wb_en           = rf.wb_bus[0];
    assign wb_rd           = rf.wb_bus[ADDR_W:1];
    assign wb_value        = rf.wb_bus[ADDR_W+DATA_W:ADDR_W+1];
    assign unused_out_port = ^rf.wb_bus[2*DATA_W+ADDR_W:ADDR_W+DATA_W+1];

    assign iss_full = rf.iss_en && (cnt_q[rf.iss_rd] == '1);

    // Retire is applied before issue so a same-register pair nets to zero.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (wb_en) begin
            regs_d[wb_rd] = wb_value;
            if (cnt_q[wb_rd] != '0) begin
                cnt_d[wb_rd] = cnt_q[wb_rd] - CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end
        if (rf.iss_en && !iss_full) begin
            cnt_d[rf.iss_rd] = cnt_d[rf.iss_rd] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

`ifdef RF_BYPASS_EN
    logic rs1_hit, rs2_hit;

    assign rs1_hit = wb_en && (wb_rd == rf.rs1_addr);
    assign rs2_hit = wb_en && (wb_rd == rf.rs2_addr);

    assign rf.rs1_data = rs1_hit ? wb_value : regs_q[rf.rs1_addr];
    assign rf.rs2_data = rs2_hit ? wb_value : regs_q[rf.rs2_addr];

    // A retire landing on the last pending write resolves the source this cycle.
    assign rs1_busy = (cnt_q[rf.rs1_addr] != '0) &&
                      !(rs1_hit && (cnt_q[rf.rs1_addr] == CNT_W'(1)));
    assign rs2_busy = (cnt_q[rf.rs2_addr] != '0) &&
                      !(rs2_hit && (cnt_q[rf.rs2_addr] == CNT_W'(1)));
`else
    assign rf.rs1_data = regs_q[rf.rs1_addr];
    assign rf.rs2_data = regs_q[rf.rs2_addr];
    assign rs1_busy    = cnt_q[rf.rs1_addr] != '0;
    assign rs2_busy    = cnt_q[rf.rs2_addr] != '0;
`endif

    assign rf.rs1_busy = rs1_busy;
    assign rf.rs2_busy = rs2_busy;
    assign rf.iss_full = iss_full;
    assign rf.stall    = rs1_busy | rs2_busy | iss_full;
    assign rf.err      = err_q;

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed self-checking bench for writeback_register_file; expectations follow RF_BYPASS_EN.
module tb_writeback_register_file;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    writeback_register_file_if #(.DATA_W(16), .ADDR_W(3)) rf_if ();

    writeback_register_file #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] rd, input logic [15:0] val, input logic en);
        rf_if.wb_bus = {16'hDEAD, val, rd, en};
    endtask

    task automatic idle();
        wb(3'd0, 16'h0000, 1'b0);
        rf_if.iss_en = 1'b0;
        rf_if.iss_rd = 3'd0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        rf_if.rs1_addr = 3'd1;
        rf_if.rs2_addr = 3'd0;
        // Activity during reset must be lost
        wb(3'd1, 16'hAAAA, 1'b1);
        rf_if.iss_en = 1'b1;
        rf_if.iss_rd = 3'd1;
        tick(); tick(); tick();
        idle();
        rst = 1'b1;
        #1;
        check("rst_data1", 32'(rf_if.rs1_data), 32'h0);
        check("rst_busy1", 32'(rf_if.rs1_busy), 32'h0);
        check("rst_stall", 32'(rf_if.stall), 32'h0);
        check("rst_err",   32'(rf_if.err), 32'h0);

        // Issue rd=5, then retire with 0xBEEF
        rf_if.iss_en = 1'b1;
        rf_if.iss_rd = 3'd5;
        tick();
        idle();
        rf_if.rs1_addr = 3'd5;
        #1;
        check("iss5_busy",  32'(rf_if.rs1_busy), 32'h1);
        check("iss5_stall", 32'(rf_if.stall), 32'h1);
        check("iss5_data",  32'(rf_if.rs1_data), 32'h0);
        wb(3'd5, 16'hBEEF, 1'b1);
        #1;
        check("ret5_data_same", 32'(rf_if.rs1_data), BYP ? 32'hBEEF : 32'h0);
        check("ret5_busy_same", 32'(rf_if.rs1_busy), BYP ? 32'h0 : 32'h1);
        tick();
        idle();
        #1;
        check("ret5_data_next", 32'(rf_if.rs1_data), 32'hBEEF);
        check("ret5_busy_next", 32'(rf_if.rs1_busy), 32'h0);
        check("ret5_err",       32'(rf_if.err), 32'h0);

        // Saturation on rd=2
        rf_if.rs1_addr = 3'd0;
        rf_if.rs2_addr = 3'd2;
        rf_if.iss_en   = 1'b1;
        rf_if.iss_rd   = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sat_notfull", 32'(rf_if.iss_full), 32'h0);
            tick();
        end
        check("sat_full",  32'(rf_if.iss_full), 32'h1);
        check("sat_stall", 32'(rf_if.stall), 32'h1);
        tick();
        idle();
        #1;
        check("sat_busy3", 32'(rf_if.rs2_busy), 32'h1);
        wb(3'd2, 16'h0001, 1'b1);
        #1;
        check("sat_ret1_busy_same", 32'(rf_if.rs2_busy), 32'h1);
        tick();
        idle();
        #1;
        check("sat_ret1_busy", 32'(rf_if.rs2_busy), 32'h1);
        wb(3'd2, 16'h0002, 1'b1);
        tick();
        idle();
        #1;
        check("sat_ret2_busy", 32'(rf_if.rs2_busy), 32'h1);
        wb(3'd2, 16'h0003, 1'b1);
        #1;
        check("sat_ret3_busy_same", 32'(rf_if.rs2_busy), BYP ? 32'h0 : 32'h1);
        tick();
        idle();
        #1;
        check("sat_ret3_busy", 32'(rf_if.rs2_busy), 32'h0);
        check("sat_data",      32'(rf_if.rs2_data), 32'h0003);
        check("sat_err",       32'(rf_if.err), 32'h0);

        // Simultaneous issue and retire on rd=3
        rf_if.rs1_addr = 3'd3;
        rf_if.rs2_addr = 3'd0;
        rf_if.iss_en   = 1'b1;
        rf_if.iss_rd   = 3'd3;
        tick();
        wb(3'd3, 16'h1234, 1'b1);
        #1;
        check("sim_notfull", 32'(rf_if.iss_full), 32'h0);
        tick();
        idle();
        #1;
        check("sim_busy", 32'(rf_if.rs1_busy), 32'h1);
        check("sim_data", 32'(rf_if.rs1_data), 32'h1234);
        check("sim_err",  32'(rf_if.err), 32'h0);
        wb(3'd3, 16'h5555, 1'b1);
        tick();
        idle();
        #1;
        check("sim_drain_busy", 32'(rf_if.rs1_busy), 32'h0);

        // Issue rd=4 while retiring rd=6 in the same cycle
        rf_if.iss_en = 1'b1;
        rf_if.iss_rd = 3'd6;
        tick();
        rf_if.iss_rd = 3'd4;
        wb(3'd6, 16'h0606, 1'b1);
        tick();
        idle();
        rf_if.rs1_addr = 3'd4;
        rf_if.rs2_addr = 3'd6;
        #1;
        check("ind_busy4", 32'(rf_if.rs1_busy), 32'h1);
        check("ind_busy6", 32'(rf_if.rs2_busy), 32'h0);
        check("ind_data6", 32'(rf_if.rs2_data), 32'h0606);
        check("ind_err",   32'(rf_if.err), 32'h0);

        // Retire with no pending write sets sticky err
        wb(3'd7, 16'h00FF, 1'b1);
        tick();
        idle();
        rf_if.rs1_addr = 3'd7;
        #1;
        check("err_data7", 32'(rf_if.rs1_data), 32'h00FF);
        check("err_set",   32'(rf_if.err), 32'h1);
        tick(); tick();
        check("err_sticky", 32'(rf_if.err), 32'h1);

        // Asynchronous reset between edges clears pending count on rd=4
        check("pre_rst_busy4", 32'(rf_if.rs2_busy | rf_if.rs1_busy), 32'h0);
        rf_if.rs2_addr = 3'd4;
        #1;
        check("pre_rst_busy4b", 32'(rf_if.rs2_busy), 32'h1);
        rf_if.iss_en = 1'b1;
        rf_if.iss_rd = 3'd4;
        #1;
        rst = 1'b0;
        #1;
        check("arst_busy4", 32'(rf_if.rs2_busy), 32'h0);
        check("arst_err",   32'(rf_if.err), 32'h0);
        check("arst_data7", 32'(rf_if.rs1_data), 32'h0);
        check("arst_stall", 32'(rf_if.stall), 32'h0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        check("post_rst_busy4", 32'(rf_if.rs2_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
